time_set_ctrl: RTL
==================

Name: time_set_ctrl

Overview:
- User-facing sequencer that edits the BCD wall-clock time field by field and loads the result into clockWorkDec through its time_in/time_ow overwrite port.
- Sits between debounced front-panel buttons and clockWorkDec.
- Captures the running time, lets the user step hour, minute and second up or down with BCD wrap, then issues a single-cycle overwrite. It can also abort the edit without writing.

Parameters:
- TIMEOUT_CYC, 6000: idle cycles allowed in any edit state before the edit aborts with no write.
- TO_W, 13: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- btn_mode  input  1  level, debounced; advances the field or commits
- btn_inc  input  1  level, debounced; increments the selected field
- btn_dec  input  1  level, debounced; decrements the selected field
- btn_cancel  input  1  level, debounced; aborts the edit
- time_cur  input  20  running time {hour[5:0], min[6:0], sec[6:0]}, BCD
- time_in  output  20  edit register {hour, min, sec}, BCD; feeds clockWorkDec time_in
- time_ow  output  1  one-cycle overwrite strobe
- editing  output  1  high in the HOUR, MIN and SEC states
- field_sel  output  2  0 = none, 1 = hour, 2 = min, 3 = sec

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
  - Reset values: state = IDLE, time_in = 20'h0, time_ow = 0, editing = 0, field_sel = 0, timeout counter = 0, button history registers = 0.
  - rst asserted mid-edit returns to IDLE and no time_ow is issued.
- Press detection:
  - Each button has a history flop.
  - A press is btn = 1 while its history bit = 0. Holding a button produces exactly one press.
  - The action takes effect on the same edge the press is sampled, so the new time_in is visible the following cycle.
- Press priority within one cycle: cancel > mode > inc/dec. If inc and dec are pressed together, both are ignored.
- States: IDLE, HOUR, MIN, SEC, COMMIT.
- IDLE:
  - mode press loads time_cur into time_in and goes to HOUR.
  - Any BCD field in time_cur that is invalid (hour > 0x23, min or sec > 0x59, or a digit > 9) is loaded as 0x00.
  - inc, dec and cancel presses are ignored.
- HOUR / MIN / SEC:
  - mode press advances HOUR -> MIN -> SEC -> COMMIT.
  - cancel press goes to IDLE; time_in keeps its value and no strobe is issued.
- Increment (BCD, per field):
  - Units digit 9 -> 0 and tens digit + 1.
  - Hour 0x23 -> 0x00; min/sec 0x59 -> 0x00.
- Decrement (BCD, per field):
  - Units digit 0 -> 9 and tens digit - 1.
  - 0x00 -> 0x23 for hour, 0x00 -> 0x59 for min/sec.
- Only the selected field changes; the other fields are held.
- COMMIT:
  - Lasts exactly one cycle; time_ow = 1, and time_in is stable during and after it.
  - Next state is IDLE unconditionally. Presses during COMMIT are ignored, but button history still updates.
- Timeout:
  - The counter clears on entry to HOUR and on any accepted press.
  - It increments each cycle while in HOUR, MIN or SEC.
  - When it reaches TIMEOUT_CYC - 1 with no press, the next state is IDLE with no strobe.
- Outputs: editing and field_sel are registered and track the state (field_sel = 1/2/3 for HOUR/MIN/SEC, 0 otherwise).

Optional Feature:
- Macro: AUTOREPEAT_EN.
- With the macro defined:
  - Holding inc or dec in an edit state repeats the action, first after REPEAT_DLY = 50 held cycles, then every REPEAT_RATE = 10 cycles.
  - Each repeat reloads the timeout counter.
  - Repeat stops as soon as the button is released, or when both inc and dec are high.
- Without the macro: strictly one action per press, and no repeat counters are present in the RTL.

Test Plan:
- Basic edit and commit:
  - Stimulus: rst 2 cycles; time_cur = {6'h23, 7'h48, 7'h00}; mode press; inc ×1; mode; mode; mode.
  - Required response: field_sel sequence 1, 2, 3; hour wraps 0x23 -> 0x00; time_ow high for exactly one cycle with time_in = {6'h00, 7'h48, 7'h00}; editing = 0 afterwards.
- BCD decade and decrement wrap:
  - Stimulus: in MIN with min = 0x09, inc.
  - Required response: 0x10. From 0x10, dec -> 0x09; from 0x00, dec -> 0x59. In SEC from 0x59, inc -> 0x00; hour and min unchanged.
- Held button and invalid capture:
  - Stimulus: hold btn_inc high for 30 cycles in HOUR (AUTOREPEAT_EN undefined).
  - Required response: hour advances by exactly 1.
  - Stimulus: capture time_cur hour = 6'h2A.
  - Required response: time_in hour = 0x00.
- Cancel and priority:
  - Stimulus: in MIN, cancel and inc pressed in the same cycle.
  - Required response: next state IDLE, min not incremented, time_ow never asserted.
  - Stimulus: inc and dec pressed together.
  - Required response: no change.
- Timeout and reset:
  - Stimulus: TIMEOUT_CYC = 20; enter HOUR and wait.
  - Required response: IDLE reached after 20 idle cycles with no time_ow. A press at cycle 15 extends this to 20 cycles after the press.
  - Stimulus: rst in SEC.
  - Required response: IDLE, time_in = 0, no strobe.
- Autorepeat (AUTOREPEAT_EN defined):
  - Stimulus: hold inc for 100 cycles in SEC starting at 0x00.
  - Required response: sec = 0x06 (initial press, repeat at cycle 50, then every 10 cycles).

Source files
------------

// File: rtl/time_set_ctrl.sv
// Front-panel time editor: captures time_cur, steps hour/min/sec in BCD, then strobes time_ow.
// Optional build macro AUTOREPEAT_EN adds hold-to-repeat on inc/dec.
module time_set_ctrl #(
  parameter int TIMEOUT_CYC = 6000,
  parameter int TO_W        = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_cancel,
  input  logic [19:0] time_cur,
  output logic [19:0] time_in,
  output logic        time_ow,
  output logic        editing,
  output logic [1:0]  field_sel
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOUR   = 3'd1,
    ST_MIN    = 3'd2,
    ST_SEC    = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  state_t          state_r, state_nx_s;
  logic [19:0]     time_in_r, time_nx_s;
  logic            time_ow_r, editing_r;
  logic [1:0]      field_sel_r, field_nx_s;
  logic [TO_W-1:0] to_cnt_r;
  logic            mode_h_r, inc_h_r, dec_h_r, cancel_h_r;

  logic mode_p_s, inc_p_s, dec_p_s, cancel_p_s;
  logic inc_act_s, dec_act_s, step_up_s, step_dn_s;
  logic edit_cur_s, edit_nx_s, to_end_s, to_clr_s;
  logic [6:0] fld_s, fld_lim_s, fld_new_s;
  logic [5:0] cap_h_s;
  logic [6:0] cap_m_s, cap_s_s;

  // Field fits 7 bits: tens in [6:4], units in [3:0]; hour is zero-extended.
  function automatic logic bcd_valid(input logic [6:0] v, input logic [6:0] lim);
    return (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

  function automatic logic [6:0] bcd_inc(input logic [6:0] v, input logic [6:0] lim);
    logic [6:0] r;
    if (v == lim)
      r = 7'h00;
    else if (v[3:0] == 4'd9)
      r = {v[6:4] + 3'd1, 4'd0};
    else
      r = {v[6:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] bcd_dec(input logic [6:0] v, input logic [6:0] lim);
    logic [6:0] r;
    if (v == 7'h00)
      r = lim;
    else if (v[3:0] == 4'd0)
      r = {v[6:4] - 3'd1, 4'd9};
    else
      r = {v[6:4], v[3:0] - 4'd1};
    return r;
  endfunction

  assign mode_p_s   = btn_mode   & ~mode_h_r;
  assign inc_p_s    = btn_inc    & ~inc_h_r;
  assign dec_p_s    = btn_dec    & ~dec_h_r;
  assign cancel_p_s = btn_cancel & ~cancel_h_r;
  assign inc_act_s  = inc_p_s & ~dec_p_s;
  assign dec_act_s  = dec_p_s & ~inc_p_s;
  assign edit_cur_s = (state_r == ST_HOUR) || (state_r == ST_MIN) || (state_r == ST_SEC);
  assign to_end_s   = (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));

  assign cap_h_s = bcd_valid({1'b0, time_cur[19:14]}, 7'h23) ? time_cur[19:14] : 6'h00;
  assign cap_m_s = bcd_valid(time_cur[13:7], 7'h59) ? time_cur[13:7] : 7'h00;
  assign cap_s_s = bcd_valid(time_cur[6:0], 7'h59) ? time_cur[6:0] : 7'h00;

`ifdef AUTOREPEAT_EN
  localparam logic [5:0] REPEAT_DLY  = 6'd50;
  localparam logic [5:0] REPEAT_RATE = 6'd10;

  logic [5:0] rep_cnt_r;
  logic       held_s, rep_fire_s;

  // A repeat needs exactly one of inc/dec held past its press edge.
  assign held_s     = edit_cur_s & ((btn_inc & inc_h_r & ~btn_dec) | (btn_dec & dec_h_r & ~btn_inc));
  assign rep_fire_s = held_s & (rep_cnt_r == 6'd0);
  assign step_up_s  = inc_act_s | (rep_fire_s & btn_inc);
  assign step_dn_s  = dec_act_s | (rep_fire_s & btn_dec);

  // Repeat countdown: first fire REPEAT_DLY cycles after the press, then every REPEAT_RATE.
  always_ff @(posedge clk) begin
    if (rst)
      rep_cnt_r <= 6'd0;
    else if (inc_p_s || dec_p_s)
      rep_cnt_r <= REPEAT_DLY - 6'd1;
    else if (held_s)
      rep_cnt_r <= (rep_cnt_r == 6'd0) ? (REPEAT_RATE - 6'd1) : (rep_cnt_r - 6'd1);
    else
      rep_cnt_r <= rep_cnt_r;
  end
`else
  assign step_up_s = inc_act_s;
  assign step_dn_s = dec_act_s;
`endif

  // Select the field being edited and its wrap limit.
  always_comb begin
    fld_s     = 7'h00;
    fld_lim_s = 7'h59;
    case (state_r)
      ST_HOUR: begin
        fld_s     = {1'b0, time_in_r[19:14]};
        fld_lim_s = 7'h23;
      end
      ST_MIN:  fld_s = time_in_r[13:7];
      ST_SEC:  fld_s = time_in_r[6:0];
      default: fld_s = 7'h00;
    endcase
    if (step_up_s)
      fld_new_s = bcd_inc(fld_s, fld_lim_s);
    else
      fld_new_s = bcd_dec(fld_s, fld_lim_s);
  end

  // Next-state and edit-register logic; priority cancel > mode > inc/dec > timeout.
  always_comb begin
    state_nx_s = state_r;
    time_nx_s  = time_in_r;
    to_clr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mode_p_s) begin
          state_nx_s = ST_HOUR;
          time_nx_s  = {cap_h_s, cap_m_s, cap_s_s};
          to_clr_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_HOUR, ST_MIN, ST_SEC: begin
        if (cancel_p_s) begin
          state_nx_s = ST_IDLE;
        end else if (mode_p_s) begin
          to_clr_s = 1'b1;
          if (state_r == ST_HOUR)
            state_nx_s = ST_MIN;
          else if (state_r == ST_MIN)
            state_nx_s = ST_SEC;
          else
            state_nx_s = ST_COMMIT;
        end else if (step_up_s || step_dn_s) begin
          to_clr_s = 1'b1;
          if (state_r == ST_HOUR)
            time_nx_s = {fld_new_s[5:0], time_in_r[13:0]};
          else if (state_r == ST_MIN)
            time_nx_s = {time_in_r[19:14], fld_new_s, time_in_r[6:0]};
          else
            time_nx_s = {time_in_r[19:7], fld_new_s};
        end else if (to_end_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_COMMIT: state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // Registered status outputs follow the next state.
  always_comb begin
    edit_nx_s = 1'b0;
    case (state_nx_s)
      ST_HOUR: begin field_nx_s = 2'd1; edit_nx_s = 1'b1; end
      ST_MIN:  begin field_nx_s = 2'd2; edit_nx_s = 1'b1; end
      ST_SEC:  begin field_nx_s = 2'd3; edit_nx_s = 1'b1; end
      default: field_nx_s = 2'd0;
    endcase
  end

  // State, edit register, outputs, timeout counter and button history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      time_in_r   <= 20'h0;
      time_ow_r   <= 1'b0;
      editing_r   <= 1'b0;
      field_sel_r <= 2'd0;
      to_cnt_r    <= '0;
      mode_h_r    <= 1'b0;
      inc_h_r     <= 1'b0;
      dec_h_r     <= 1'b0;
      cancel_h_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      time_in_r   <= time_nx_s;
      time_ow_r   <= (state_nx_s == ST_COMMIT);
      editing_r   <= edit_nx_s;
      field_sel_r <= field_nx_s;
      to_cnt_r    <= (!edit_nx_s || to_clr_s) ? '0 : (to_cnt_r + TO_W'(1));
      mode_h_r    <= btn_mode;
      inc_h_r     <= btn_inc;
      dec_h_r     <= btn_dec;
      cancel_h_r  <= btn_cancel;
    end
  end

  assign time_in   = time_in_r;
  assign time_ow   = time_ow_r;
  assign editing   = editing_r;
  assign field_sel = field_sel_r;

endmodule
